// File: rtl/lsu.sv
// Load/store unit: turns hart memory requests into a single valid/ready word-bus
// transaction, extracts/extends load lanes, and stalls the hart until completion.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] memaddr,
  input  logic        memw,
  input  logic [1:0]  memwidth,
  input  logic        memsext,
  input  logic [31:0] memwdata,
  output logic [31:0] memdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic        sext_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        fault_q;
  logic [15:0] cnt;
  logic [31:0] memdata_q;

  logic        misalign;
  logic        timeout;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_comb begin
    misalign   = 1'b0;
    lane_wdata = memwdata;
    lane_wstrb = 4'b1111;
    case (memwidth)
      2'b00: begin
        lane_wdata = {4{memwdata[7:0]}};
        lane_wstrb = 4'b0001 << memaddr[1:0];
      end
      2'b01: begin
        misalign   = memaddr[0];
        lane_wdata = {2{memwdata[15:0]}};
        lane_wstrb = 4'b0011 << {memaddr[1], 1'b0};
      end
      2'b10:   misalign = |memaddr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = bus_rdata >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (width_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel[7:0]};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = bus_rdata;
    endcase
  end

  // Counter holds the number of completed REQ/WAIT cycles; the current one is the last allowed.
  assign timeout = (cnt >= TO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = misalign ? DONE : REQ;
      REQ: begin
        if (bus_ready)    state_nx = we_q ? DONE : WAIT;
        else if (timeout) state_nx = DONE;
      end
      WAIT: if (bus_rvalid || timeout) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      width_q   <= '0;
      sext_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      fault_q   <= 1'b0;
      cnt       <= '0;
      memdata_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          fault_q <= 1'b0;
          if (req) begin
            addr_q  <= memaddr;
            width_q <= memwidth;
            sext_q  <= memsext;
            we_q    <= memw;
            wdata_q <= lane_wdata;
            wstrb_q <= memw ? lane_wstrb : 4'b0000;
            fault_q <= misalign;
            cnt     <= '0;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (!bus_ready && timeout) begin
            fault_q   <= 1'b1;
            memdata_q <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (bus_rvalid) begin
            memdata_q <= load_val;
          end else if (timeout) begin
            fault_q   <= 1'b1;
            memdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_valid = (state == REQ);
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_we    = we_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign memdata   = memdata_q;
  assign fault     = (state == DONE) & fault_q;
  assign stall     = reset & req & (state != DONE);

endmodule
